osd_event_packetization_mc: RTL and testbench
=============================================

Name: osd_event_packetization_mc

Overview:
- Multi-channel successor to the single-source event packetizer.
- NUM_CH independent event sources share one DI output port. A round-robin arbiter selects one source per event.
- The event payload is split into DI packets (DEST, SRC, FLAGS, payload) of at most MAX_PKT_LEN flits.
- Adds zero-length events and optional channel tagging in FLAGS.

Parameters:
- MAX_PKT_LEN, 12: maximum DI packet length in flits, including 3 header flits; must be ≥ 4.
- MAX_DATA_NUM_WORDS, 32: maximum payload words per event; must be ≥ 1.
- NUM_CH, 2: number of event sources, 1..16.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- debug_out  out  dii_flit  DI flit (valid, data[15:0], last)
- debug_out_ready  in  1  sink accepts flit
- id  in  16  DI source address
- dest  in  16  DI event destination
- event_available  in  NUM_CH  per-channel event pending
- overflow  in  NUM_CH  per-channel: send overflow packet instead of event
- data_num_words  in  NUM_CH*$clog2(MAX_DATA_NUM_WORDS+1)  per-channel word count, channel c at slice c
- event_consumed  out  NUM_CH  one-hot, 1-cycle pulse when channel's event is fully sent
- data_req_ch  out  max(1,$clog2(NUM_CH))  granted channel
- data_req_idx  out  max(1,$clog2(MAX_DATA_NUM_WORDS))  requested word index
- data_req_valid  out  1  request valid
- data  in  16  word for (data_req_ch, data_req_idx), combinational response

Behaviour:
- Reset values: state IDLE, debug_out.valid=0, debug_out.last=0, event_consumed=0, data_req_valid=0, data_req_ch=0, word/packet/flit counters=0, RR pointer=channel 0.
- rst mid-event aborts without event_consumed. The source keeps event_available asserted and is re-served from word 0.
- Constants: P = MAX_PKT_LEN-3 payload flits per packet; num_pkgs = ceil(N/P), where N is the granted channel's data_num_words. N=0 counts as 1 packet.
- States: IDLE, DEST, SRC, FLAGS, OVERFLOW, PAYLOAD.
- IDLE: if any event_available, grant the first requester at or after the RR pointer. Latch grant, advance pointer to grant+1 (mod NUM_CH), go to DEST. One dead cycle; no output in IDLE.
- Grant is held for all packets of the event. Inputs of the granted channel must stay stable until event_consumed.
- DEST: valid=1, data=dest. On ready → SRC.
- SRC: valid=1, data=id. On ready → FLAGS.
- FLAGS: data[15:14]=2'b10; [13:10] as below; [9:0]=0 unless the optional feature is enabled.
  - [13:10]=5 if overflow.
  - Else [13:10]=0 if pkg_cnt==num_pkgs-1.
  - Else [13:10]=1.
- FLAGS, N==0 and no overflow: last=1. On ready, pulse event_consumed, → IDLE.
- FLAGS otherwise: on ready → OVERFLOW or PAYLOAD.
- OVERFLOW: valid=1, data=data (idx 0), last=1. On ready, pulse event_consumed, → IDLE.
- PAYLOAD: valid=1, data=data. last=1 when word_cnt==N-1 or flit_cnt==P-1. On ready:
  - If final word: event_consumed pulse, clear counters, → IDLE.
  - Else if packet full: pkg_cnt++, flit_cnt=0, word_cnt++, → DEST. Header is re-sent; no re-arbitration.
  - Else: word_cnt++, flit_cnt++.
- data_req_valid=1 in OVERFLOW and PAYLOAD only.
- Handshake: while valid && !ready, data and last stay stable and nothing advances.
- Arithmetic: compare in width $clog2(MAX_DATA_NUM_WORDS+1); no underflow on N-1 when N=0.
- Throughput: one flit per cycle under continuous ready.

Optional Feature:
- Macro: OSD_EVENT_PACKETIZATION_CH_TAG_EN.
- Defined: FLAGS[3:0] = granted channel index (zero-extended).
- Undefined: FLAGS[9:0] = 0, bit-identical to the single-channel format.

Decomposition:
- Package osd_event_packetization_pkg: TYPE_EVENT=2'b10, TYPE_SUB_LAST=4'h0, TYPE_SUB_CONTINUE=4'h1, TYPE_SUB_OVERFLOW=4'h5, NUM_HEADER_FLITS=3, state enum typedef.
- Sub-module osd_rr_arbiter #(N): request vector, update strobe → one-hot grant plus index. Pointer updates only on strobe.

Test Plan:
- MAX_PKT_LEN=12, ch0 N=20, ready=1 → 3 packets with payloads 9, 9, 2; FLAGS 0x8400, 0x8400, 0x8000; last on the 12th, 12th and 5th flit; one event_consumed[0] pulse.
- ch1 N=0 → DEST, SRC, FLAGS=0x8000 with last=1; event_consumed[1] pulses; data_req_valid never asserts.
- ch0 and ch1 both available, N=3 each, twice → served ch0, ch1, ch0, ch1; data_req_ch matches grant.
- ch0 overflow=1, data=0x0007 → FLAGS=0x9400, then payload 0x0007 with last=1, then event_consumed.
- N=10, ready toggles 1/0 each cycle → flit sequence identical to ready=1; data stable while stalled.
- rst asserted mid-PAYLOAD of word 4 → next cycle valid=0; event restarts at word 0 with no consumed pulse.
- With CH_TAG_EN, NUM_CH=4, ch3 N=1 → FLAGS=0x8003.

Source files
------------

// File: rtl/osd_event_packetization_pkg.sv
// Shared constants, FSM state encoding and DI flit type for the multi-channel event packetizer.
// Optional channel tagging in FLAGS is selected by OSD_EVENT_PACKETIZATION_CH_TAG_EN.
package osd_event_packetization_pkg;

  localparam logic [1:0] TYPE_EVENT        = 2'b10;
  localparam logic [3:0] TYPE_SUB_LAST     = 4'h0;
  localparam logic [3:0] TYPE_SUB_CONTINUE = 4'h1;
  localparam logic [3:0] TYPE_SUB_OVERFLOW = 4'h5;
  localparam int         NUM_HEADER_FLITS  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEST,
    ST_SRC,
    ST_FLAGS,
    ST_OVERFLOW,
    ST_PAYLOAD
  } state_e;

  typedef struct packed {
    logic        valid;
    logic [15:0] data;
    logic        last;
  } dii_flit;

  // Packets needed for n payload words at p words per packet; an empty event still needs one.
  function automatic int calc_num_pkgs(input int n, input int p);
    return (n == 0) ? 1 : (n + p - 1) / p;
  endfunction

endpackage

// File: rtl/osd_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer; the pointer
// moves past the grant only when update is strobed.
module osd_rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          update,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_req
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found_hi;
  logic [IW-1:0] idx_hi, idx_lo;

  always_comb begin
    found_hi = 1'b0;
    any_req  = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    // Descending scan leaves the lowest matching index in each candidate.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (IW'(i) >= ptr_q) begin
          found_hi = 1'b1;
          idx_hi   = IW'(i);
        end
        any_req = 1'b1;
        idx_lo  = IW'(i);
      end
    end
    grant_idx = found_hi ? idx_hi : idx_lo;
    for (int i = 0; i < N; i++) begin
      grant[i] = any_req && (grant_idx == IW'(i));
    end
    ptr_d = ptr_q;
    if (update && any_req) begin
      ptr_d = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/osd_event_packetization_mc.sv
// Multi-channel DI event packetizer: round-robin picks a source, its event is split into
// DEST/SRC/FLAGS/payload packets. OSD_EVENT_PACKETIZATION_CH_TAG_EN puts the channel in FLAGS[3:0].
module osd_event_packetization_mc
  import osd_event_packetization_pkg::*;
#(
  parameter  int MAX_PKT_LEN        = 12,
  parameter  int MAX_DATA_NUM_WORDS = 32,
  parameter  int NUM_CH             = 2,
  localparam int CW  = $clog2(MAX_DATA_NUM_WORDS + 1),
  localparam int IW  = (MAX_DATA_NUM_WORDS > 1) ? $clog2(MAX_DATA_NUM_WORDS) : 1,
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  output dii_flit            debug_out,
  input  logic               debug_out_ready,
  input  logic [15:0]        id,
  input  logic [15:0]        dest,
  input  logic [NUM_CH-1:0]  event_available,
  input  logic [NUM_CH-1:0]  overflow,
  input  logic [NUM_CH*CW-1:0] data_num_words,
  output logic [NUM_CH-1:0]  event_consumed,
  output logic [CHW-1:0]     data_req_ch,
  output logic [IW-1:0]      data_req_idx,
  output logic               data_req_valid,
  input  logic [15:0]        data
);

  localparam int P  = MAX_PKT_LEN - NUM_HEADER_FLITS;
  localparam int FW = $clog2(MAX_PKT_LEN);

  state_e            state_q, state_d;
  logic [CHW-1:0]    grant_ch_q, grant_ch_d;
  logic [NUM_CH-1:0] grant_oh_q, grant_oh_d;
  logic [CW-1:0]     word_cnt_q, word_cnt_d;
  logic [CW-1:0]     pkg_cnt_q, pkg_cnt_d;
  logic [FW-1:0]     flit_cnt_q, flit_cnt_d;

  logic [NUM_CH-1:0] arb_grant;
  logic [CHW-1:0]    arb_idx;
  logic              arb_any;
  logic              arb_update;

  logic [CW-1:0]     cur_n;
  logic              cur_ovf;
  logic [CW-1:0]     num_pkgs;
  logic              last_pkt, last_word, pkt_full, n_zero, fin;
  logic [3:0]        flags_sub;
  logic [9:0]        flags_low;

  osd_rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (event_available),
    .update    (arb_update),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  always_comb begin
    cur_n   = '0;
    cur_ovf = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant_oh_q[c]) begin
        cur_n   = data_num_words[c*CW +: CW];
        cur_ovf = overflow[c];
      end
    end
  end

  // Compare "word_cnt+1 == N" rather than "word_cnt == N-1" so N=0 cannot wrap.
  assign num_pkgs  = CW'(calc_num_pkgs(int'(cur_n), P));
  assign last_pkt  = (pkg_cnt_q == num_pkgs - CW'(1));
  assign last_word = (word_cnt_q + CW'(1) == cur_n);
  assign pkt_full  = (flit_cnt_q == FW'(P - 1));
  assign n_zero    = (cur_n == '0);
  assign flags_sub = cur_ovf  ? TYPE_SUB_OVERFLOW :
                     last_pkt ? TYPE_SUB_LAST : TYPE_SUB_CONTINUE;

`ifdef OSD_EVENT_PACKETIZATION_CH_TAG_EN
  assign flags_low = {6'b0, 4'(grant_ch_q)};
`else
  assign flags_low = '0;
`endif

  // Output flit is decoded from registered state only (plus the combinational data word).
  // valid/ready: a flit transfers on a cycle with valid && ready; while valid && !ready
  // data and last hold and no state or counter advances.
  always_comb begin
    debug_out = '0;
    case (state_q)
      ST_DEST:     debug_out = '{valid: 1'b1, data: dest, last: 1'b0};
      ST_SRC:      debug_out = '{valid: 1'b1, data: id,   last: 1'b0};
      ST_FLAGS:    debug_out = '{valid: 1'b1, data: {TYPE_EVENT, flags_sub, flags_low},
                                 last: n_zero && !cur_ovf};
      ST_OVERFLOW: debug_out = '{valid: 1'b1, data: data, last: 1'b1};
      ST_PAYLOAD:  debug_out = '{valid: 1'b1, data: data, last: last_word || pkt_full};
      default:     debug_out = '0;
    endcase
  end

  assign data_req_valid = (state_q == ST_OVERFLOW) || (state_q == ST_PAYLOAD);
  assign data_req_idx   = word_cnt_q[IW-1:0];
  assign data_req_ch    = grant_ch_q;
  assign event_consumed = fin ? grant_oh_q : '0;

  always_comb begin
    state_d    = state_q;
    grant_ch_d = grant_ch_q;
    grant_oh_d = grant_oh_q;
    word_cnt_d = word_cnt_q;
    pkg_cnt_d  = pkg_cnt_q;
    flit_cnt_d = flit_cnt_q;
    arb_update = 1'b0;
    fin        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          grant_ch_d = arb_idx;
          grant_oh_d = arb_grant;
          arb_update = 1'b1;
          state_d    = ST_DEST;
        end
      end
      ST_DEST:  if (debug_out_ready) state_d = ST_SRC;
      ST_SRC:   if (debug_out_ready) state_d = ST_FLAGS;
      ST_FLAGS: begin
        if (debug_out_ready) begin
          if (cur_ovf)     state_d = ST_OVERFLOW;
          else if (n_zero) begin
            fin     = 1'b1;
            state_d = ST_IDLE;
          end else         state_d = ST_PAYLOAD;
        end
      end
      ST_OVERFLOW: begin
        if (debug_out_ready) begin
          fin     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_PAYLOAD: begin
        if (debug_out_ready) begin
          if (last_word) begin
            fin     = 1'b1;
            state_d = ST_IDLE;
          end else if (pkt_full) begin
            pkg_cnt_d  = pkg_cnt_q + CW'(1);
            word_cnt_d = word_cnt_q + CW'(1);
            flit_cnt_d = '0;
            state_d    = ST_DEST;
          end else begin
            word_cnt_d = word_cnt_q + CW'(1);
            flit_cnt_d = flit_cnt_q + FW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (fin) begin
      word_cnt_d = '0;
      pkg_cnt_d  = '0;
      flit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_ch_q <= '0;
      grant_oh_q <= '0;
      word_cnt_q <= '0;
      pkg_cnt_q  <= '0;
      flit_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_ch_q <= grant_ch_d;
      grant_oh_q <= grant_oh_d;
      word_cnt_q <= word_cnt_d;
      pkg_cnt_q  <= pkg_cnt_d;
      flit_cnt_q <= flit_cnt_d;
    end
  end

endmodule

// File: tb/tb_osd_event_packetization_mc.sv
// Bench for osd_event_packetization_mc: queued event sources, a packet-level reference model
// feeding an expected-flit queue, and a monitor that checks every accepted flit.
module tb_osd_event_packetization_mc;
  import osd_event_packetization_pkg::*;

  localparam int MAX_PKT_LEN = 12;
  localparam int MAX_W       = 32;
`ifdef OSD_EVENT_PACKETIZATION_CH_TAG_EN
  localparam int NUM_CH = 4;
`else
  localparam int NUM_CH = 2;
`endif
  localparam int CW  = $clog2(MAX_W + 1);
  localparam int IW  = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int P   = MAX_PKT_LEN - 3;
  localparam int EW  = 2 + CHW + 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  dii_flit              debug_out;
  logic                 debug_out_ready = 1'b1;
  logic [15:0]          id = 16'h0;
  logic [15:0]          dest = 16'h0;
  logic [NUM_CH-1:0]    event_available = '0;
  logic [NUM_CH-1:0]    overflow = '0;
  logic [NUM_CH*CW-1:0] data_num_words = '0;
  logic [NUM_CH-1:0]    event_consumed;
  logic [CHW-1:0]       data_req_ch;
  logic [IW-1:0]        data_req_idx;
  logic                 data_req_valid;
  logic [15:0]          data;

  typedef struct {
    int         n;
    bit         ovf;
    logic [7:0] tag;
  } ev_t;

  ev_t         src_q [NUM_CH][$];
  logic [7:0]  head_tag [NUM_CH];
  logic [EW-1:0] exp_q[$];
  int          exp_cons_q[$];
  int          checks = 0;
  int          passed = 0;
  int          acc_cnt = 0;
  int          m_ptr = 0;
  int          rdy_mode = 0;
  bit          mon_en = 1'b0;

  osd_event_packetization_mc #(
    .MAX_PKT_LEN(MAX_PKT_LEN), .MAX_DATA_NUM_WORDS(MAX_W), .NUM_CH(NUM_CH)
  ) dut (
    .clk(clk), .rst(rst), .debug_out(debug_out), .debug_out_ready(debug_out_ready),
    .id(id), .dest(dest), .event_available(event_available), .overflow(overflow),
    .data_num_words(data_num_words), .event_consumed(event_consumed),
    .data_req_ch(data_req_ch), .data_req_idx(data_req_idx),
    .data_req_valid(data_req_valid), .data(data)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Source data word: event tag in the high byte, word index in the low byte.
  always_comb data = {head_tag[data_req_ch], 8'(data_req_idx)};

  always begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       debug_out_ready = 1'b1;
      1:       debug_out_ready = ~debug_out_ready;
      default: debug_out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  // ---------------- driver tasks ----------------
  task automatic refresh_src();
    for (int c = 0; c < NUM_CH; c++) begin
      if (src_q[c].size() > 0) begin
        event_available[c]           = 1'b1;
        overflow[c]                  = src_q[c][0].ovf;
        data_num_words[c*CW +: CW]   = CW'(src_q[c][0].n);
        head_tag[c]                  = src_q[c][0].tag;
      end else begin
        event_available[c]           = 1'b0;
        overflow[c]                  = 1'b0;
        data_num_words[c*CW +: CW]   = '0;
        head_tag[c]                  = 8'h00;
      end
    end
  endtask

  task automatic add_ev(input int c, input int n, input bit ovf);
    ev_t e;
    e.n   = n;
    e.ovf = ovf;
    e.tag = 8'($urandom_range(0, 255));
    src_q[c].push_back(e);
  endtask

  // ---------------- reference model ----------------
  task automatic push_flit(input bit last, input bit rv, input int c, input logic [15:0] d);
    exp_q.push_back({last, rv, CHW'(c), d});
  endtask

  task automatic push_header(input int c, input logic [3:0] sub, input bit last);
    logic [9:0] low;
`ifdef OSD_EVENT_PACKETIZATION_CH_TAG_EN
    low = 10'(c);
`else
    low = 10'd0;
`endif
    push_flit(1'b0, 1'b0, c, dest);
    push_flit(1'b0, 1'b0, c, id);
    push_flit(last, 1'b0, c, {2'b10, sub, low});
  endtask

  task automatic build_expected();
    ev_t mq [NUM_CH][$];
    ev_t e;
    int  sel;
    bit  found;
    for (int c = 0; c < NUM_CH; c++) mq[c] = src_q[c];
    forever begin
      found = 1'b0;
      sel   = 0;
      for (int k = 0; k < NUM_CH; k++) begin
        int cc;
        cc = (m_ptr + k) % NUM_CH;
        if (!found && mq[cc].size() > 0) begin
          found = 1'b1;
          sel   = cc;
        end
      end
      if (!found) break;
      m_ptr = (sel + 1) % NUM_CH;
      e = mq[sel].pop_front();
      if (e.ovf) begin
        push_header(sel, 4'h5, 1'b0);
        push_flit(1'b1, 1'b1, sel, {e.tag, 8'h00});
      end else if (e.n == 0) begin
        push_header(sel, 4'h0, 1'b1);
      end else begin
        for (int start = 0; start < e.n; start += P) begin
          int len;
          len = (e.n - start < P) ? e.n - start : P;
          push_header(sel, (start + len == e.n) ? 4'h0 : 4'h1, 1'b0);
          for (int j = 0; j < len; j++)
            push_flit(j == len - 1, 1'b1, sel, {e.tag, 8'(start + j)});
        end
      end
      exp_cons_q.push_back(sel);
    end
  endtask

  task automatic start_phase(input int mode);
    rdy_mode = mode;
    id       = 16'($urandom_range(0, 65535));
    dest     = 16'($urandom_range(0, 65535));
    build_expected();
    refresh_src();
  endtask

  function automatic bit all_empty();
    bit e;
    e = (exp_q.size() == 0) && (exp_cons_q.size() == 0);
    for (int c = 0; c < NUM_CH; c++) if (src_q[c].size() > 0) e = 1'b0;
    return e;
  endfunction

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (all_empty()) return;
    end
    check("drain_pending", exp_q.size() + exp_cons_q.size(), 0);
    exp_q.delete();
    exp_cons_q.delete();
    for (int c = 0; c < NUM_CH; c++) src_q[c].delete();
    refresh_src();
    rst = 1'b1;
    m_ptr = 0;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [EW-1:0]     act;
    logic [16:0]       prev;
    bit                stall_prev;
    logic [NUM_CH-1:0] pend;
    stall_prev = 1'b0;
    prev       = '0;
    forever begin
      @(negedge clk);
      pend = '0;
      if (mon_en && !rst) begin
        if (stall_prev) check("stall_hold", {debug_out.last, debug_out.data}, prev);
        if (debug_out.valid && debug_out_ready) begin
          act = {debug_out.last, data_req_valid, data_req_ch, debug_out.data};
          if (exp_q.size() == 0) check("flit_unexpected", exp_q.size(), 1);
          else check("flit", act, exp_q.pop_front());
          acc_cnt++;
        end else if (!debug_out.valid) begin
          check("idle_outputs", {data_req_valid, debug_out.last}, 0);
        end
        if (event_consumed != '0) begin
          if (exp_cons_q.size() == 0) check("consumed_unexpected", event_consumed, 0);
          else check("consumed", event_consumed, 1 << exp_cons_q.pop_front());
        end
        stall_prev = debug_out.valid && !debug_out_ready;
        prev       = {debug_out.last, debug_out.data};
        pend       = event_consumed;
      end else begin
        stall_prev = 1'b0;
      end
      @(posedge clk); #1;
      if (pend != '0) begin
        for (int c = 0; c < NUM_CH; c++) if (pend[c]) void'(src_q[c].pop_front());
        refresh_src();
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int base;
    refresh_src();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", debug_out.valid, 0);
    check("rst_last", debug_out.last, 0);
    check("rst_consumed", event_consumed, 0);
    check("rst_req_valid", data_req_valid, 0);
    check("rst_req_ch", data_req_ch, 0);
    @(posedge clk); #2;
    rst    = 1'b0;
    mon_en = 1'b1;

    add_ev(0, 20, 1'b0);                     // three packets: 9, 9, 2 payload words
    start_phase(0);
    wait_drain(2000);

    add_ev(1, 0, 1'b0);                      // header-only event
    start_phase(0);
    wait_drain(2000);

    add_ev(0, 3, 1'b0); add_ev(0, 3, 1'b0);  // competing channels alternate
    add_ev(1, 3, 1'b0); add_ev(1, 3, 1'b0);
    start_phase(0);
    wait_drain(2000);

    add_ev(0, 5, 1'b1);                      // overflow packet
    start_phase(0);
    wait_drain(2000);

    add_ev(0, 10, 1'b0);                     // ready toggling every cycle
    start_phase(1);
    wait_drain(2000);

    add_ev(NUM_CH - 1, 1, 1'b0);             // highest channel, single word
    start_phase(0);
    wait_drain(2000);

    // Reset while payload word 4 is on the output: event must restart from word 0.
    add_ev(0, 10, 1'b0);
    start_phase(0);
    base = acc_cnt;
    for (int i = 0; i < 200 && acc_cnt < base + 7; i++) begin
      @(posedge clk); #2;
    end
    check("rst_reached_word4", acc_cnt - base, 7);
    rst = 1'b1;
    exp_q.delete();
    exp_cons_q.delete();
    m_ptr = 0;
    @(posedge clk); #2;
    check("rst_abort_valid", debug_out.valid, 0);
    rst = 1'b0;
    build_expected();
    wait_drain(2000);

    for (int ph = 0; ph < 25; ph++) begin
      int total;
      total = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        int k;
        k = $urandom_range(0, 2);
        for (int j = 0; j < k; j++) begin
          add_ev(c, $urandom_range(0, MAX_W), $urandom_range(0, 7) == 0);
          total++;
        end
      end
      if (total == 0) add_ev($urandom_range(0, NUM_CH - 1), $urandom_range(0, MAX_W), 1'b0);
      start_phase($urandom_range(0, 2));
      wait_drain(5000);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
